// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
//
// Holds the PC and issues word fetches to a variable-latency instruction memory
// (req/ready handshake). It presents IF_instr/IF_pcplus4/IF_valid for IF/ID to
// capture and drives IF_flush on a branch/jump redirect. PC_write=0 stalls
// sequential advance. A redirect that arrives while a request is outstanding
// drains that stale response before refetching.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   PC_write         hazard-unit enable (0 = hold fetch and PC)
//   redirect_en/pc   taken branch/jump and its target
//   imem_req/addr    fetch request (level-held) and address
//   imem_ready/rdata memory response handshake and data
//   IF_instr         instruction to IF/ID (0 when IF_valid=0)
//   IF_pcplus4       fetched address + 4 (0 when IF_valid=0)
//   IF_valid         IF_instr/IF_pcplus4 carry a real instruction
//   IF_flush         zero IF/ID at the next edge (= redirect_en)
//   fetch_pc         current architectural PC (debug)
//   fetch_misalign   sticky misaligned-redirect flag (IF_MISALIGN_TRAP_EN only)
//
// Optional feature macro: IF_MISALIGN_TRAP_EN. When defined, a redirect with
// redirect_pc[1:0]!=0 sets fetch_misalign and jumps to TRAP_VEC. When undefined,
// redirect_pc[1:0] are forced to zero.
// All outputs are forced to 0 while rst=1.
module if_fetch_unit #(
  parameter int unsigned     word     = 32,
  parameter logic [word-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [word-1:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_write,
  input  logic            redirect_en,
  input  logic [word-1:0] redirect_pc,
  output logic            imem_req,
  output logic [word-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [word-1:0] imem_rdata,
  output logic [word-1:0] IF_instr,
  output logic [word-1:0] IF_pcplus4,
  output logic            IF_valid,
  output logic            IF_flush,
`ifdef IF_MISALIGN_TRAP_EN
  output logic            fetch_misalign,
`endif
  output logic [word-1:0] fetch_pc
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  localparam logic [word-1:0] Four = word'(4);

  state_e          state_q, state_d;
  logic [word-1:0] pc_q, pc_d;
  logic [word-1:0] req_addr_q, req_addr_d;
  logic [word-1:0] hold_instr_q, hold_instr_d;
  logic [word-1:0] seq_addr;
  logic [word-1:0] redir_tgt;

  logic            req_c, valid_c;
  logic [word-1:0] instr_c;

  assign seq_addr = req_addr_q + Four;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q;
  logic redir_misaligned;

  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redir_tgt        = redir_misaligned ? TRAP_VEC : redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_en && redir_misaligned) begin
      misalign_q <= 1'b1;
    end
  end

  assign fetch_misalign = misalign_q;
`else
  logic unused_redir_lsbs;

  // Targets are word-aligned; low bits are dropped.
  assign redir_tgt         = {redirect_pc[word-1:2], 2'b00};
  assign unused_redir_lsbs = ^redirect_pc[1:0];
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    req_c        = 1'b0;
    valid_c      = 1'b0;
    instr_c      = '0;

    unique case (state_q)
      StFetch: begin
        req_c = 1'b1;
        if (imem_ready) begin
          valid_c = 1'b1;
          instr_c = imem_rdata;
        end
        if (redirect_en) begin
          pc_d = redir_tgt;
          if (imem_ready) begin
            req_addr_d = redir_tgt;
          end else begin
            // Outstanding request must complete before the new fetch is issued.
            state_d = StDrain;
          end
        end else if (imem_ready) begin
          if (PC_write) begin
            pc_d       = seq_addr;
            req_addr_d = seq_addr;
          end else begin
            hold_instr_d = imem_rdata;
            state_d      = StHold;
          end
        end
      end

      StHold: begin
        valid_c = 1'b1;
        instr_c = hold_instr_q;
        if (redirect_en) begin
          pc_d       = redir_tgt;
          req_addr_d = redir_tgt;
          state_d    = StFetch;
        end else if (PC_write) begin
          pc_d       = seq_addr;
          req_addr_d = seq_addr;
          state_d    = StFetch;
        end
      end

      StDrain: begin
        // Keep requesting the stale address; its data is discarded.
        req_c = 1'b1;
        if (redirect_en) begin
          pc_d = redir_tgt;
        end
        if (imem_ready) begin
          req_addr_d = redirect_en ? redir_tgt : pc_q;
          state_d    = StFetch;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Outputs are gated so that nothing leaks out while reset is held.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    IF_instr   = '0;
    IF_pcplus4 = '0;
    IF_valid   = 1'b0;
    IF_flush   = 1'b0;
    fetch_pc   = '0;
    if (!rst) begin
      imem_req   = req_c;
      imem_addr  = req_addr_q;
      IF_valid   = valid_c;
      IF_instr   = valid_c ? instr_c : '0;
      IF_pcplus4 = valid_c ? seq_addr : '0;
      IF_flush   = redirect_en;
      fetch_pc   = pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a scoreboard of expected IF/ID outputs.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PC_write;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_instr;
  logic [31:0] IF_pcplus4;
  logic        IF_valid;
  logic        IF_flush;
  logic [31:0] fetch_pc;

`ifdef IF_MISALIGN_TRAP_EN
  logic        fetch_misalign;
  localparam logic [31:0] MisTgt = 32'h0000_0080;
`else
  localparam logic [31:0] MisTgt = 32'h0000_0040;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] p4;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PC_write   (PC_write),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .IF_instr   (IF_instr),
    .IF_pcplus4 (IF_pcplus4),
    .IF_valid   (IF_valid),
    .IF_flush   (IF_flush),
`ifdef IF_MISALIGN_TRAP_EN
    .fetch_misalign(fetch_misalign),
`endif
    .fetch_pc   (fetch_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Compares IF/ID outputs against the scoreboard head when the DUT says valid.
  task automatic check_if(input string tag, input logic exp_valid);
    exp_t e;
    chk({tag, ".valid"}, {31'd0, IF_valid}, {31'd0, exp_valid});
    if (IF_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk({tag, ".instr"}, IF_instr, e.instr);
        chk({tag, ".pcplus4"}, IF_pcplus4, e.p4);
      end
    end else begin
      chk({tag, ".instr0"}, IF_instr, 32'd0);
      chk({tag, ".p4_0"}, IF_pcplus4, 32'd0);
    end
  endtask

  // One clock: drive at posedge+1, check at the falling edge, advance.
  task automatic cyc(input string tag, input logic rdy, input logic [31:0] rdata,
                     input logic pcw, input logic redir, input logic [31:0] rpc,
                     input logic exp_req, input logic [31:0] exp_addr,
                     input logic exp_valid, input logic [31:0] exp_instr,
                     input logic [31:0] exp_p4);
    exp_t e;
    imem_ready  = rdy;
    imem_rdata  = rdata;
    PC_write    = pcw;
    redirect_en = redir;
    redirect_pc = rpc;
    if (exp_valid) begin
      e.instr = exp_instr;
      e.p4    = exp_p4;
      sb_q.push_back(e);
    end
    #4;
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, exp_req});
    chk({tag, ".addr"}, imem_addr, exp_addr);
    chk({tag, ".flush"}, {31'd0, IF_flush}, {31'd0, redir});
    check_if(tag, exp_valid);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, ".addr"}, imem_addr, 32'd0);
    chk({tag, ".valid"}, {31'd0, IF_valid}, 32'd0);
    chk({tag, ".flush"}, {31'd0, IF_flush}, 32'd0);
    chk({tag, ".instr"}, IF_instr, 32'd0);
    chk({tag, ".p4"}, IF_pcplus4, 32'd0);
    chk({tag, ".pc"}, fetch_pc, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    PC_write    = 1'b1;
    redirect_en = 1'b1;  // must not leak out as IF_flush during reset
    redirect_pc = 32'h0000_0040;
    imem_ready  = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #4;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst         = 1'b0;
    redirect_en = 1'b0;

    // Zero-bubble streaming with a 1-cycle memory.
    for (int i = 0; i < 4; i++) begin
      cyc("stream", 1'b1, mem_of(32'(4 * i)), 1'b1, 1'b0, 32'd0,
          1'b1, 32'(4 * i), 1'b1, mem_of(32'(4 * i)), 32'(4 * i + 4));
    end
    chk("stream.pc", fetch_pc, 32'h10);

    // Async reset mid-cycle, then a 3-cycle memory latency.
    imem_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("async_rst1");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("lat_wait", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    end
    cyc("lat_done", 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 32'd0,
        1'b1, 32'd0, 1'b1, 32'hDEAD_0001, 32'd4);

    // Stall with a valid response: hold it until PC_write returns.
    cyc("hold_in", 1'b1, 32'h8C01_0004, 1'b0, 1'b0, 32'd0,
        1'b1, 32'd4, 1'b1, 32'h8C01_0004, 32'd8);
    for (int i = 0; i < 2; i++) begin
      cyc("hold", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd4, 1'b1, 32'h8C01_0004, 32'd8);
    end
    chk("hold.pc", fetch_pc, 32'd4);
    cyc("hold_out", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd4, 1'b1, 32'h8C01_0004, 32'd8);
    cyc("after_hold", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd8, 1'b0, 32'd0, 32'd0);
    cyc("f8", 1'b1, mem_of(32'd8), 1'b1, 1'b0, 32'd0, 1'b1, 32'd8, 1'b1, mem_of(32'd8), 32'd12);
    cyc("f12", 1'b1, mem_of(32'd12), 1'b1, 1'b0, 32'd0,
        1'b1, 32'd12, 1'b1, mem_of(32'd12), 32'd16);

    // Redirect while the request to 0x10 is outstanding: drain it.
    cyc("redir_pend", 1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'd0, 32'd0);
    chk("drain.pc", fetch_pc, 32'h40);
    cyc("drain_wait", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, 32'd0, 32'd0);
    cyc("drain_drop", 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'd0,
        1'b1, 32'h10, 1'b0, 32'd0, 32'd0);
    cyc("f40", 1'b1, mem_of(32'h40), 1'b1, 1'b0, 32'd0,
        1'b1, 32'h40, 1'b1, mem_of(32'h40), 32'h44);

    // Enter DRAIN again and hit it with an async reset.
    cyc("redir2", 1'b0, 32'd0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h44, 1'b0, 32'd0, 32'd0);
    redirect_en = 1'b0;
    imem_ready  = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("async_rst2");
    @(posedge clk);
    #1 rst = 1'b0;

    // Misaligned redirect, taken on a cycle that also completes a fetch.
    cyc("mis_redir", 1'b1, mem_of(32'd0), 1'b1, 1'b1, 32'h42,
        1'b1, 32'd0, 1'b1, mem_of(32'd0), 32'd4);
    cyc("mis_addr", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, MisTgt, 1'b0, 32'd0, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
`endif

    // PC+4 wraps at the top of the address space.
    cyc("wrap_redir", 1'b1, mem_of(MisTgt), 1'b1, 1'b1, 32'hFFFF_FFFC,
        1'b1, MisTgt, 1'b1, mem_of(MisTgt), MisTgt + 32'd4);
    cyc("wrap_top", 1'b1, mem_of(32'hFFFF_FFFC), 1'b1, 1'b0, 32'd0,
        1'b1, 32'hFFFF_FFFC, 1'b1, mem_of(32'hFFFF_FFFC), 32'd0);
    cyc("wrap_zero", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_sticky", {31'd0, fetch_misalign}, 32'd1);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
